seg7_scan_controller: RTL and testbench

- Time-multiplexing scheduler for the 4-digit 7-segment display on the Basys 3.
- Holds a tear-free 16-bit display value and rotates one digit slot at a fixed refresh rate.
- Drives the 2-bit digit select and 4-bit nibble into the existing combinational hex-decoder/anode-select stage.
- Adds frame-synchronous loading, decimal points, leading-zero blanking and enable gating.

---
 rtl/seg7_scan_controller.sv | 105 ++++++++++
 tb/tb_seg7_scan_controller.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_controller.sv
// Digit-scan scheduler for a 4-digit multiplexed 7-segment display.
// Rotates one digit per refresh slot and commits queued values only at the frame boundary.
module seg7_scan_controller #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned CNT_W       = 17
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        ENABLE,
  input  logic        LOAD,
  input  logic [15:0] DATA_IN,
  input  logic [3:0]  DP_IN,
  input  logic        BLANK_LZ,
  output logic [1:0]  SEG_SELECT_OUT,
  output logic [3:0]  NUMBER_OUT,
  output logic        DOT_OUT,
  output logic        DIGIT_EN_OUT,
  output logic        PENDING_OUT,
  output logic        FRAME_TICK_OUT
);

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] prescaler;
  logic [1:0]       idx;
  logic [15:0]      disp_reg;
  logic [15:0]      pend_reg;
  logic [3:0]       dp_reg;
  logic [3:0]       pend_dp;
  logic             pending;
  logic             frame_tick;
  logic             scan_live;
  logic             tick;
  logic             commit;
  logic [3:0]       lz;
  logic             digit_en;

  assign tick   = ENABLE & (prescaler == PRE_LAST);
  assign commit = tick & (idx == 2'd3);

  // Prescaler and digit index; frozen while disabled.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      prescaler <= '0;
      idx       <= 2'd0;
    end else if (tick) begin
      prescaler <= '0;
      idx       <= idx + 2'd1;
    end else if (ENABLE) begin
      prescaler <= prescaler + CNT_W'(1);
    end
  end

  // Queue and frame-synchronous commit; a load on the commit cycle bypasses the queue.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      disp_reg <= 16'h0000;
      dp_reg   <= 4'h0;
      pend_reg <= 16'h0000;
      pend_dp  <= 4'h0;
      pending  <= 1'b0;
    end else if (commit) begin
      if (LOAD) begin
        disp_reg <= DATA_IN;
        dp_reg   <= DP_IN;
      end else if (pending) begin
        disp_reg <= pend_reg;
        dp_reg   <= pend_dp;
      end
      pending <= 1'b0;
    end else if (LOAD) begin
      pend_reg <= DATA_IN;
      pend_dp  <= DP_IN;
      pending  <= 1'b1;
    end
  end

  // scan_live keeps the digit dark during reset even if ENABLE is already high.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      frame_tick <= 1'b0;
      scan_live  <= 1'b0;
    end else begin
      frame_tick <= commit;
      scan_live  <= 1'b1;
    end
  end

  // Leading-zero mask: digit i is a leading zero when it and every higher nibble are zero.
  always_comb begin
    lz    = 4'b0000;
    lz[3] = BLANK_LZ & (disp_reg[15:12] == 4'h0);
    lz[2] = lz[3] & (disp_reg[11:8] == 4'h0);
    lz[1] = lz[2] & (disp_reg[7:4] == 4'h0);
  end

  assign digit_en       = ENABLE & scan_live & ~(lz[idx] & ~dp_reg[idx]);
  assign SEG_SELECT_OUT = idx;
  assign NUMBER_OUT     = disp_reg[{idx, 2'b00} +: 4];
  assign DOT_OUT        = dp_reg[idx] & digit_en;
  assign DIGIT_EN_OUT   = digit_en;
  assign PENDING_OUT    = pending;
  assign FRAME_TICK_OUT = frame_tick;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Self-checking bench for seg7_scan_controller with a slot-time reference model.
module tb_seg7_scan_controller;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [1:0]  seg_sel;
  logic [3:0]  number;
  logic        dot;
  logic        digit_en;
  logic        pending;
  logic        frame_tick;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: t counts enabled cycles within the frame since reset.
  int          t;
  logic [15:0] m_disp;
  logic [3:0]  m_dp;
  logic [15:0] m_q;
  logic [3:0]  m_qdp;
  bit          m_qpend;
  bit          m_alive;
  bit          m_ftick;

  always #5 clk = ~clk;

  seg7_scan_controller #(.REFRESH_DIV(DIV), .CNT_W(3)) dut (
    .CLK(clk), .RESETN(rst_n), .ENABLE(enable), .LOAD(load),
    .DATA_IN(data_in), .DP_IN(dp_in), .BLANK_LZ(blank_lz),
    .SEG_SELECT_OUT(seg_sel), .NUMBER_OUT(number), .DOT_OUT(dot),
    .DIGIT_EN_OUT(digit_en), .PENDING_OUT(pending), .FRAME_TICK_OUT(frame_tick)
  );

  task automatic model_reset();
    t = 0; m_disp = '0; m_dp = '0; m_q = '0; m_qdp = '0;
    m_qpend = 0; m_alive = 0; m_ftick = 0;
  endtask

  task automatic model_step();
    bit tick, commit;
    tick   = enable && (t % DIV == DIV - 1);
    commit = tick && (t / DIV == 3);
    m_ftick = commit;
    m_alive = 1;
    if (commit) begin
      if (load) begin m_disp = data_in; m_dp = dp_in; end
      else if (m_qpend) begin m_disp = m_q; m_dp = m_qdp; end
      m_qpend = 0;
    end else if (load) begin
      m_q = data_in; m_qdp = dp_in; m_qpend = 1;
    end
    if (enable) t = (t + 1) % FRAME;
  endtask

  function automatic logic [9:0] exp_vec();
    int idx;
    bit blank, en;
    idx   = t / DIV;
    blank = blank_lz && idx >= 1 && ((m_disp >> (4 * idx)) == 16'h0);
    en    = enable && m_alive && !(blank && !m_dp[idx]);
    return {2'(idx), 4'(m_disp >> (4 * idx)), m_dp[idx] && en, en, m_qpend, m_ftick};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic wait_t(input int target);
    int n = 0;
    while (t != target && n < 64) begin cycle(); n++; end
    if (t != target) begin
      vectors++; miscompares++;
      $display("FAIL wait_t: slot time %0d, required %0d", t, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; enable = 1; load = 0; data_in = '0; dp_in = '0; blank_lz = 0;
    model_reset();
    @(posedge clk); #1;
    vectors++;
    if ({seg_sel, number, dot, digit_en, pending, frame_tick} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want %b", {seg_sel, number, dot, digit_en, pending, frame_tick}, 10'b0);
    end
    @(negedge clk); rst_n = 1;
    cycle();
    vectors++;
    if ({seg_sel, number, dot, digit_en, pending, frame_tick} !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_release: got %b want %b", {seg_sel, number, dot, digit_en, pending, frame_tick}, exp_vec());
    end
  endtask

  task automatic test_scan();
    int last = -1;
    for (int n = 0; n < 48; n++) begin
      cycle();
      vectors++;
      if ({seg_sel, number, dot, digit_en, pending, frame_tick} !== exp_vec()) begin
        miscompares++;
        $display("FAIL scan: got %b want %b", {seg_sel, number, dot, digit_en, pending, frame_tick}, exp_vec());
      end
      if (frame_tick === 1'b1) begin
        if (last >= 0) begin
          vectors++;
          if (n - last != FRAME) begin
            miscompares++;
            $display("FAIL frame_tick_period: got %0d want %0d", n - last, FRAME);
          end
        end
        last = n;
      end
    end
    vectors++;
    if (last < 0) begin
      miscompares++;
      $display("FAIL frame_tick_seen: got none want pulse");
    end
  endtask

  task automatic test_load();
    logic [3:0] seq [4];
    seq[0] = 4'h7; seq[1] = 4'hF; seq[2] = 4'h3; seq[3] = 4'hA;
    wait_t(DIV);
    data_in = 16'hA3F7; load = 1;
    cycle();
    load = 0;
    while (t != 0) begin
      vectors++;
      if (pending !== 1'b1 || number !== 4'h0) begin
        miscompares++;
        $display("FAIL load_queued: got pend=%b num=%h want pend=1 num=0", pending, number);
      end
      cycle();
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (number !== seq[k] || pending !== 1'b0 || seg_sel !== 2'(k)) begin
        miscompares++;
        $display("FAIL load_sequence: got sel=%0d num=%h pend=%b want sel=%0d num=%h pend=0", seg_sel, number, pending, k, seq[k]);
      end
      for (int c = 0; c < DIV; c++) cycle();
    end
  endtask

  task automatic test_overwrite();
    wait_t(2);  data_in = 16'h1111; load = 1; cycle(); load = 0;
    wait_t(6);  data_in = 16'h2222; load = 1; cycle(); load = 0;
    wait_t(0);
    vectors++;
    if (number !== 4'h2 || pending !== 1'b0) begin
      miscompares++;
      $display("FAIL overwrite_last_wins: got num=%h pend=%b want num=2 pend=0", number, pending);
    end
    wait_t(FRAME - 1);
    data_in = 16'h5555; load = 1; cycle(); load = 0;
    vectors++;
    if (number !== 4'h5 || pending !== 1'b0 || frame_tick !== 1'b1) begin
      miscompares++;
      $display("FAIL load_on_commit: got num=%h pend=%b tick=%b want num=5 pend=0 tick=1", number, pending, frame_tick);
    end
  endtask

  task automatic test_blank();
    logic [3:0] en_map;
    blank_lz = 1;
    wait_t(DIV); data_in = 16'h0040; dp_in = 4'b1000; load = 1; cycle(); load = 0; dp_in = 4'b0000;
    wait_t(0);
    en_map = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (digit_en !== en_map[k] || dot !== (k == 3)) begin
        miscompares++;
        $display("FAIL blank_dp: idx %0d got en=%b dot=%b want en=%b dot=%b", k, digit_en, dot, en_map[k], k == 3);
      end
      for (int c = 0; c < DIV; c++) cycle();
    end
    wait_t(DIV); data_in = 16'h0000; load = 1; cycle(); load = 0;
    wait_t(0);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (digit_en !== (k == 0)) begin
        miscompares++;
        $display("FAIL blank_zero: idx %0d got en=%b want en=%b", k, digit_en, k == 0);
      end
      for (int c = 0; c < DIV; c++) cycle();
    end
    blank_lz = 0;
  endtask

  task automatic test_enable();
    wait_t(2 * DIV + 1);
    enable = 0;
    for (int n = 0; n < 10; n++) begin
      cycle();
      vectors++;
      if (seg_sel !== 2'd2 || digit_en !== 1'b0 || dot !== 1'b0
          || {seg_sel, number, dot, digit_en, pending, frame_tick} !== exp_vec()) begin
        miscompares++;
        $display("FAIL enable_freeze: got sel=%0d en=%b dot=%b want sel=2 en=0 dot=0", seg_sel, digit_en, dot);
      end
    end
    enable = 1;
    for (int n = 1; n <= 3; n++) begin
      cycle();
      vectors++;
      if (seg_sel !== ((n < 3) ? 2'd2 : 2'd3)) begin
        miscompares++;
        $display("FAIL enable_resume: after %0d cycles got sel=%0d want %0d", n, seg_sel, (n < 3) ? 2 : 3);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      enable  = ($urandom % 8) != 0;
      load    = ($urandom % 6) == 0;
      data_in = 16'($urandom);
      dp_in   = 4'($urandom);
      if ($urandom % 20 == 0) blank_lz = ~blank_lz;
      if ($urandom % 3 == 0) data_in = data_in & 16'h00FF;
      #1;
      vectors++;
      if ({seg_sel, number, dot, digit_en, pending, frame_tick} !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_pre: got %b want %b", {seg_sel, number, dot, digit_en, pending, frame_tick}, exp_vec());
      end
      cycle();
      vectors++;
      if ({seg_sel, number, dot, digit_en, pending, frame_tick} !== exp_vec()) begin
        miscompares++;
        $display("FAIL random: got %b want %b", {seg_sel, number, dot, digit_en, pending, frame_tick}, exp_vec());
      end
    end
    load = 0; enable = 1; blank_lz = 0;
  endtask

  task automatic test_async_reset();
    wait_t(5);
    data_in = 16'h1234; dp_in = 4'b0101; load = 1; cycle(); load = 0;
    vectors++;
    if (pending !== 1'b1) begin
      miscompares++;
      $display("FAIL async_pre: got pend=%b want 1", pending);
    end
    #2 rst_n = 0;
    #1;
    vectors++;
    if ({seg_sel, number, dot, digit_en, pending, frame_tick} !== 10'b0) begin
      miscompares++;
      $display("FAIL async_reset: got %b want %b", {seg_sel, number, dot, digit_en, pending, frame_tick}, 10'b0);
    end
    @(posedge clk); @(negedge clk);
    rst_n = 1; model_reset();
    for (int n = 0; n < FRAME + 2; n++) begin
      cycle();
      vectors++;
      if (pending !== 1'b0 || number !== 4'h0
          || {seg_sel, number, dot, digit_en, pending, frame_tick} !== exp_vec()) begin
        miscompares++;
        $display("FAIL async_release: got %b want %b", {seg_sel, number, dot, digit_en, pending, frame_tick}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_overwrite();
    test_blank();
    test_enable();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
